// File: rtl/cpu.sv
// Minimal 8-bit single-cycle processor: 16-word parameterised program ROM,
// four general registers exposed on reg1..reg4, Z/C flags and a sticky halt.
module cpu #(
    parameter logic [255:0] PROGRAM = 256'h0000_0000_0000_0000_0000_0000_0000_0000_F000_7100_4D00_2C00_3900_2800_1403_1005
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    output logic [7:0] reg1,
    output logic [7:0] reg2,
    output logic [7:0] reg3,
    output logic [7:0] reg4
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_DEC  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Word i of the ROM image lives at bits [16*i+15 : 16*i].
    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        logic [7:0] base;
        base = {idx, 4'h0};
        return PROGRAM[base +: 16];
    endfunction

    logic [7:0] regs_r [0:3];
    logic [3:0] pc_r;
    logic       z_r;
    logic       c_r;
    logic       halted_r;

    logic [15:0] instr_s;
    logic [3:0]  op_s;
    logic [1:0]  rd_s;
    logic [1:0]  rs_s;
    logic [7:0]  imm_s;
    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic [8:0]  wide_s;
    logic [7:0]  result_s;
    logic        carry_s;
    logic        wr_en_s;
    logic        z_en_s;
    logic        c_en_s;
    logic        halt_s;
    logic [3:0]  pc_next_s;
    logic        step_s;

    // Instruction fetch and field decode from the current PC.
    always_comb begin
        instr_s = rom_word(pc_r);
        op_s    = instr_s[15:12];
        rd_s    = instr_s[11:10];
        rs_s    = instr_s[9:8];
        imm_s   = instr_s[7:0];
        a_s     = regs_r[rd_s];
        b_s     = regs_r[rs_s];
        step_s  = cs & ~halted_r;
    end

    // Execute: ALU result, flag enables and next PC for the fetched instruction.
    always_comb begin
        wide_s    = 9'h000;
        result_s  = 8'h00;
        carry_s   = c_r;
        wr_en_s   = 1'b0;
        z_en_s    = 1'b0;
        c_en_s    = 1'b0;
        halt_s    = 1'b0;
        pc_next_s = pc_r + 4'd1;
        case (op_s)
            OP_NOP: begin
                wr_en_s = 1'b0;
            end
            OP_LDI: begin
                result_s = imm_s;
                wr_en_s  = 1'b1;
            end
            OP_MOV: begin
                result_s = b_s;
                wr_en_s  = 1'b1;
            end
            OP_ADD: begin
                wide_s   = {1'b0, a_s} + {1'b0, b_s};
                result_s = wide_s[7:0];
                carry_s  = wide_s[8];
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
                c_en_s   = 1'b1;
            end
            OP_SUB: begin
                // Bit 8 of the 9-bit difference is the borrow (a < b).
                wide_s   = {1'b0, a_s} - {1'b0, b_s};
                result_s = wide_s[7:0];
                carry_s  = wide_s[8];
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
                c_en_s   = 1'b1;
            end
            OP_AND: begin
                result_s = a_s & b_s;
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
            end
            OP_OR: begin
                result_s = a_s | b_s;
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
            end
            OP_XOR: begin
                result_s = a_s ^ b_s;
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
            end
            OP_NOT: begin
                result_s = ~a_s;
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
            end
            OP_SHL: begin
                result_s = {a_s[6:0], 1'b0};
                carry_s  = a_s[7];
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
                c_en_s   = 1'b1;
            end
            OP_SHR: begin
                result_s = {1'b0, a_s[7:1]};
                carry_s  = a_s[0];
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
                c_en_s   = 1'b1;
            end
            OP_INC: begin
                wide_s   = {1'b0, a_s} + 9'd1;
                result_s = wide_s[7:0];
                carry_s  = wide_s[8];
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
                c_en_s   = 1'b1;
            end
            OP_DEC: begin
                wide_s   = {1'b0, a_s} - 9'd1;
                result_s = wide_s[7:0];
                carry_s  = wide_s[8];
                wr_en_s  = 1'b1;
                z_en_s   = 1'b1;
                c_en_s   = 1'b1;
            end
            OP_JMP: begin
                pc_next_s = imm_s[3:0];
            end
            OP_JZ: begin
                if (z_r) begin
                    pc_next_s = imm_s[3:0];
                end else begin
                    pc_next_s = pc_r + 4'd1;
                end
            end
            OP_HALT: begin
                halt_s    = 1'b1;
                pc_next_s = pc_r;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Architectural state: commits one instruction per enabled, un-halted edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 8'h00;
            end
            pc_r     <= 4'h0;
            z_r      <= 1'b0;
            c_r      <= 1'b0;
            halted_r <= 1'b0;
        end else if (step_s) begin
            if (wr_en_s) begin
                regs_r[rd_s] <= result_s;
            end else begin
                regs_r[rd_s] <= regs_r[rd_s];
            end
            if (z_en_s) begin
                z_r <= (result_s == 8'h00);
            end else begin
                z_r <= z_r;
            end
            if (c_en_s) begin
                c_r <= carry_s;
            end else begin
                c_r <= c_r;
            end
            pc_r     <= pc_next_s;
            halted_r <= halt_s;
        end else begin
            pc_r     <= pc_r;
            z_r      <= z_r;
            c_r      <= c_r;
            halted_r <= halted_r;
        end
    end

    assign reg1 = regs_r[0];
    assign reg2 = regs_r[1];
    assign reg3 = regs_r[2];
    assign reg4 = regs_r[3];

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed vector table on the default program, a branch/flag
// program, and randomized cs/reset traffic against an ISA-level model.
module tb_cpu;

    localparam logic [255:0] PROG_A = 256'h0000_0000_0000_0000_0000_0000_0000_0000_F000_7100_4D00_2C00_3900_2800_1403_1005;
    localparam logic [255:0] PROG_B = {128'h0,
        16'hF000, 16'h4E00, 16'h9800, 16'h1801, 16'h14AA, 16'hE004, 16'hB000, 16'h10FF};
    localparam logic [255:0] PROG_C = {
        16'hD002, 16'h0000, 16'h2D00, 16'hE002, 16'h5300, 16'hC400, 16'hB800, 16'hAC00,
        16'h9000, 16'h8400, 16'h7E00, 16'h6800, 16'h4400, 16'h3100, 16'h1437, 16'h109C};

    logic clk = 1'b0;
    logic reset;
    logic cs;
    logic [7:0] a1, a2, a3, a4, b1, b2, b3, b4, c1, c2, c3, c4;

    always #5 clk = ~clk;

    cpu dut_a (.clk(clk), .reset(reset), .cs(cs), .reg1(a1), .reg2(a2), .reg3(a3), .reg4(a4));
    cpu #(.PROGRAM(PROG_B)) dut_b (.clk(clk), .reset(reset), .cs(cs), .reg1(b1), .reg2(b2), .reg3(b3), .reg4(b4));
    cpu #(.PROGRAM(PROG_C)) dut_c (.clk(clk), .reset(reset), .cs(cs), .reg1(c1), .reg2(c2), .reg3(c3), .reg4(c4));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ISA-level reference model ----------------
    logic [255:0] m_rom [3];
    logic [7:0]   m_r   [3][4];
    logic [3:0]   m_pc  [3];
    bit           m_z   [3];
    bit           m_c   [3];
    bit           m_h   [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) m_r[k][j] = 8'h00;
            m_pc[k] = 4'h0;
            m_z[k] = 1'b0;
            m_c[k] = 1'b0;
            m_h[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!m_h[k]) begin
                logic [15:0] w;
                int op, rd, rs, imm, a, b, res, npc;
                bit wr, zf, cf;
                w   = m_rom[k][m_pc[k]*16 +: 16];
                op  = w[15:12];
                rd  = w[11:10];
                rs  = w[9:8];
                imm = w[7:0];
                a   = m_r[k][rd];
                b   = m_r[k][rs];
                npc = (m_pc[k] + 1) % 16;
                wr = 1'b1; zf = 1'b1; cf = 1'b0; res = 0;
                case (op)
                    1:  begin res = imm; zf = 0; end
                    2:  begin res = b;   zf = 0; end
                    3:  begin res = a + b;   cf = 1; m_c[k] = (res > 255); end
                    4:  begin res = a - b + 256; cf = 1; m_c[k] = (a < b); end
                    5:  res = a & b;
                    6:  res = a | b;
                    7:  res = a ^ b;
                    8:  res = 255 - a;
                    9:  begin res = a * 2; cf = 1; m_c[k] = (a >= 128); end
                    10: begin res = a / 2; cf = 1; m_c[k] = (a % 2 == 1); end
                    11: begin res = a + 1; cf = 1; m_c[k] = (a == 255); end
                    12: begin res = a + 255; cf = 1; m_c[k] = (a == 0); end
                    13: begin wr = 0; zf = 0; npc = imm % 16; end
                    14: begin wr = 0; zf = 0; if (m_z[k]) npc = imm % 16; end
                    15: begin wr = 0; zf = 0; m_h[k] = 1'b1; npc = m_pc[k]; end
                    default: begin wr = 0; zf = 0; end
                endcase
                res = res % 256;
                if (wr) m_r[k][rd] = res[7:0];
                if (zf) m_z[k] = (res == 0);
                m_pc[k] = npc[3:0];
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a"}, {a1, a2, a3, a4}, {m_r[0][0], m_r[0][1], m_r[0][2], m_r[0][3]});
        check({tag, "_b"}, {b1, b2, b3, b4}, {m_r[1][0], m_r[1][1], m_r[1][2], m_r[1][3]});
        check({tag, "_c"}, {c1, c2, c3, c4}, {m_r[2][0], m_r[2][1], m_r[2][2], m_r[2][3]});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst_n;
        bit          cs;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input bit r, input bit c, input logic [31:0] e);
        vec_t v;
        v.rst_n = r; v.cs = c; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic push_run7();
        push(1, 1, 32'h05000000);
        push(1, 1, 32'h05030000);
        push(1, 1, 32'h05030500);
        push(1, 1, 32'h05030800);
        push(1, 1, 32'h05030805);
        push(1, 1, 32'h05030802);
        push(1, 1, 32'h06030802);
    endtask

    initial begin
        m_rom[0] = PROG_A;
        m_rom[1] = PROG_B;
        m_rom[2] = PROG_C;
        model_reset();
        reset = 1'b0;
        cs    = 1'b0;

        // reset held while clocking with cs toggling
        push(0, 1, 32'h0); push(0, 0, 32'h0); push(0, 1, 32'h0);
        // continuous run, then HALT holds
        push_run7();
        push(1, 1, 32'h06030802); push(1, 1, 32'h06030802); push(1, 1, 32'h06030802);
        // cs gating: 2 enabled, 3 stalled, then resume without skipping
        push(0, 1, 32'h0);
        push(1, 1, 32'h05000000); push(1, 1, 32'h05030000);
        push(1, 0, 32'h05030000); push(1, 0, 32'h05030000); push(1, 0, 32'h05030000);
        push(1, 1, 32'h05030500); push(1, 1, 32'h05030800);
        // mid-run reset after edge 4, then full re-run
        push(0, 1, 32'h0);
        push_run7();

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst_n;
            cs    = tbl[i].cs;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {a1, a2, a3, a4}, tbl[i].exp);
        end

        // halt persistence with cs toggling
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cs = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("halt_hold", {a1, a2, a3, a4}, 32'h06030802);
        end

        // async reset between edges clears without a clock
        #2 reset = 1'b0;
        #1;
        check("async_clr_a", {a1, a2, a3, a4}, 32'h0);
        check("async_clr_b", {b1, b2, b3, b4}, 32'h0);

        // branch/flag program and re-execution of the default one
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reset = 1'b1;
            cs    = 1'b1;
            @(posedge clk);
        end
        #1;
        check("branch_prog", {b1, b2, b3, b4}, 32'h000002FE);
        check("rerun_prog", {a1, a2, a3, a4}, 32'h06030802);

        // randomized cs / reset traffic against the model
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            cs    = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 63) != 0);
            if (!reset) model_reset();
            #1;
            check_model("rand_pre");
            @(posedge clk);
            if (reset && cs) model_step();
            #1;
            check_model("rand_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Minimal 8-bit single-cycle processor with an internal 16-word program ROM, four 8-bit general registers (R0..R3) and Z/C flags.
- Executes one instruction per rising clock edge while chip-select `cs` is high.
- Register file is exposed directly on `reg1`..`reg4` for observation by the surrounding system and bench.

Parameters:
- PROGRAM, 256'h0000_..._F000_7100_4D00_2C00_3900_2800_1403_1005, 16 x 16-bit ROM image; word i = PROGRAM[16*i+15:16*i]; unlisted words 0x0000 (NOP).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- cs  input  1  chip select / run enable; 1 = execute this cycle, 0 = stall
- reg1  output  8  R0 contents
- reg2  output  8  R1 contents
- reg3  output  8  R2 contents
- reg4  output  8  R3 contents

Behaviour:
- Reset (`reset`=0, async, no clock needed) clears:
  - R0..R3 = 0x00
  - PC = 0
  - Z = 0, C = 0
  - halted = 0
- All outputs are 0x00 during reset.
- Step: on rising `clk` with `reset`=1, `cs`=1 and halted=0, execute ROM[PC] and commit results in that same edge; otherwise all state holds.
- No fetch latency; a register update is visible on `regN` right after the executing edge.
- `cs` may toggle at any cycle. A cycle with `cs`=0 is a pure stall; the PC does not advance.
- Encoding: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Default PC update is PC+1, 4-bit, wrapping 15 to 0.
- Opcodes:
  - 0 NOP
  - 1 LDI: rd = imm
  - 2 MOV: rd = rs
  - 3 ADD: rd = rd+rs; C = carry out
  - 4 SUB: rd = rd-rs; C = borrow (rd<rs)
  - 5 AND, 6 OR, 7 XOR: rd = rd op rs; C unchanged
  - 8 NOT: rd = ~rd; C unchanged
  - 9 SHL: rd = rd<<1; C = old bit7
  - A SHR: rd = rd>>1 (logical); C = old bit0
  - B INC: rd = rd+1; C = 1 on 0xFF to 0x00
  - C DEC: rd = rd-1; C = 1 on 0x00 to 0xFF
  - D JMP: PC = imm[3:0]
  - E JZ: PC = imm[3:0] if Z=1, else PC+1
  - F HALT: halted = 1; PC stays at the HALT address
- Flags:
  - Z is set to (result==0) for opcodes 3-C only.
  - LDI, MOV, NOP, jumps and HALT leave Z and C unchanged.
- rd==rs is legal. Examples: XOR R0,R0 gives 0 with Z=1; ADD R1,R1 doubles R1.
- Once halted, state is frozen regardless of `cs` until reset is asserted.
- Reset asserted mid-program clears everything immediately. Execution restarts from PC=0 on the first enabled edge after release.
- Default program:
  - 0 LDI R0,5
  - 1 LDI R1,3
  - 2 MOV R2,R0
  - 3 ADD R2,R1
  - 4 MOV R3,R0
  - 5 SUB R3,R1
  - 6 XOR R0,R1
  - 7 HALT

Test Plan:
- Reset: hold `reset`=0 while toggling `clk` and `cs` -> reg1..reg4 = 0x00 throughout. Assert `reset` between edges -> outputs clear without waiting for a clock edge.
- Continuous run: release reset, `cs`=1 for 10 edges -> reg1/reg2/reg3/reg4 after edges 1..7:
  - edge 1: 05/00/00/00
  - edge 2: 05/03/00/00
  - edge 3: 05/03/05/00
  - edge 4: 05/03/08/00
  - edge 5: 05/03/08/05
  - edge 6: 05/03/08/02
  - edge 7: 06/03/08/02
  - edges 8-10 (HALT): unchanged
- `cs` gating: `cs`=1 for 2 edges, 0 for 3 edges, then 1 -> outputs hold 05/03/00/00 during the stall. The next enabled edge executes MOV R2,R0 (reg3=0x05); no instruction is skipped or repeated.
- Mid-run reset: assert reset after edge 4 (reg3=0x08) -> all outputs 0x00. After release, 7 enabled edges again reach 06/03/08/02.
- Flags/branching via PROGRAM override {LDI R0,FF; INC R0; JZ 4; LDI R1,AA; LDI R2,01; SHL R2; SUB R3,R2; HALT} -> final reg1=00, reg2=00 (branch taken), reg3=02, reg4=FE with C=1.
- Halt persistence: after HALT, toggle `cs` for 20 cycles -> outputs unchanged. Reset then release -> program re-executes from PC 0.
